// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8-bit UART receiver with a first-word-fall-through receive FIFO
// and sticky error flags (overflow, framing, parity).
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, the frame is 8E1
// (one even-parity bit between data bit 7 and the stop bit). When it is not
// defined, the frame is 8N1 and rx_parity_err is tied low.
module uart_rx_fifo #(
   parameter int CLK_DIV    = 1085,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        uart_rx,
   output logic [7:0]                  rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic [$clog2(FIFO_DEPTH):0] rx_count,
   output logic                        rx_overflow,
   output logic                        rx_frame_err,
   output logic                        rx_parity_err,
   input  logic                        err_clr
);

   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int HALF_I   = CLK_DIV / 2 - 1;
   localparam int FULL_I   = CLK_DIV - 1;
   localparam logic [15:0] HALF_BIT  = HALF_I[15:0];
   localparam logic [15:0] FULL_BIT  = FULL_I[15:0];
   localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   // Even parity: the transmitted parity bit equals the XOR of the data bits.
   function automatic logic f_even_parity(input logic [7:0] i_byte);
      return ^i_byte;
   endfunction
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;
`endif

   // Line synchronizer and receiver state
   logic        r_sync1;
   logic        r_sync2;
   logic        w_rx;
   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic [2:0]  r_idx;
   logic [2:0]  w_idx_nxt;
   logic [7:0]  r_shift;
   logic [7:0]  w_shift_nxt;
   logic        w_push_req;
   logic        w_set_frame;
`ifdef UART_RX_PARITY_EN
   logic        r_par_bad;
   logic        w_par_bad_nxt;
   logic        w_set_parity;
   logic        r_parity_err;
`endif

   // FIFO state
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [AW:0]   w_count_nxt;
   logic          r_valid;
   logic          w_pop;
   logic          w_full;
   logic          w_push;
   logic          w_drop;
   logic          r_overflow;
   logic          r_frame_err;

   assign w_rx = r_sync2;

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= uart_rx;
         r_sync2 <= r_sync1;
      end
   end

   // Receiver next-state logic: bit timing, sampling, and push/error decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_push_req  = 1'b0;
      w_set_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nxt = r_par_bad;
      w_set_parity  = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (!w_rx) begin
               w_state_nxt = S_START;
               w_cnt_nxt   = HALF_BIT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_START: begin
            if (r_cnt != 16'd0) begin
               w_cnt_nxt = r_cnt - 16'd1;
            end else if (w_rx) begin
               // Start bit vanished before mid-bit: treat as a glitch.
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DATA;
               w_cnt_nxt   = FULL_BIT;
               w_idx_nxt   = 3'd0;
            end
         end
         S_DATA: begin
            if (r_cnt != 16'd0) begin
               w_cnt_nxt = r_cnt - 16'd1;
            end else begin
               w_shift_nxt = {w_rx, r_shift[7:1]};
               w_cnt_nxt   = FULL_BIT;
               if (r_idx == 3'd7) begin
                  w_idx_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (r_cnt != 16'd0) begin
               w_cnt_nxt = r_cnt - 16'd1;
            end else begin
               w_par_bad_nxt = (w_rx != f_even_parity(r_shift));
               w_set_parity  = (w_rx != f_even_parity(r_shift));
               w_cnt_nxt     = FULL_BIT;
               w_state_nxt   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt != 16'd0) begin
               w_cnt_nxt = r_cnt - 16'd1;
            end else if (w_rx) begin
`ifdef UART_RX_PARITY_EN
               w_push_req = !r_par_bad;
`else
               w_push_req = 1'b1;
`endif
               w_state_nxt = S_IDLE;
            end else begin
               // Stop bit low: framing error, wait for the line to recover.
               w_set_frame = 1'b1;
               w_state_nxt = S_BREAK;
            end
         end
         S_BREAK: begin
            if (w_rx) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_BREAK;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 16'd0;
            w_idx_nxt   = 3'd0;
         end
      endcase
   end

   // Receiver state register and datapath.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
         r_idx   <= 3'd0;
         r_shift <= 8'd0;
`ifdef UART_RX_PARITY_EN
         r_par_bad <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
         r_par_bad <= w_par_bad_nxt;
`endif
      end
   end

   // FIFO control: a pop frees a slot in the same cycle, so a push into a full
   // FIFO that coincides with a pop is accepted.
   assign w_pop  = r_valid && rx_ready;
   assign w_full = (r_count == DEPTH_CNT);
   assign w_push = w_push_req && (!w_full || w_pop);
   assign w_drop = w_push_req && w_full && !w_pop;

   // Occupancy next value.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (AW+1)'(1'b1);
         2'b01:   w_count_nxt = r_count - (AW+1)'(1'b1);
         default: w_count_nxt = r_count;
      endcase
   end

   // FIFO storage; cleared on reset so the head reads 0x00 while in reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 8'd0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= r_shift;
      end else begin
         r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
      end
   end

   // FIFO pointers (wrap naturally at the power-of-two depth), count, valid.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1'b1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1'b1);
         end
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
      end
   end

   // Sticky error flags; a set event in the same cycle wins over err_clr.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (w_set_frame) begin
            r_frame_err <= 1'b1;
         end else if (err_clr) begin
            r_frame_err <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Sticky parity error flag; set wins over err_clr.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_parity_err <= 1'b0;
      end else if (w_set_parity) begin
         r_parity_err <= 1'b1;
      end else if (err_clr) begin
         r_parity_err <= 1'b0;
      end
   end
   assign rx_parity_err = r_parity_err;
`else
   assign rx_parity_err = 1'b0;
`endif

   assign rx_data      = r_mem[r_rd_ptr];
   assign rx_valid     = r_valid;
   assign rx_count     = r_count;
   assign rx_overflow  = r_overflow;
   assign rx_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
// (CLK_DIV=16, FIFO_DEPTH=8). Honors UART_RX_PARITY_EN the same way as the RTL.
module tb_uart_rx_fifo;

   logic       clk;
   logic       resetn;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [3:0] rx_count;
   logic       rx_overflow;
   logic       rx_frame_err;
   logic       rx_parity_err;
   logic       err_clr;

   int n_tests = 0;
   int n_fail  = 0;

   uart_rx_fifo #(.CLK_DIV(16), .FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .uart_rx      (uart_rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_count     (rx_count),
      .rx_overflow  (rx_overflow),
      .rx_frame_err (rx_frame_err),
      .rx_parity_err(rx_parity_err),
      .err_clr      (err_clr)
   );

   // 100 MHz bench clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance n rising edges, then step 1 ns past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Start bit, 8 data bits LSB first, and (parity build) the parity bit.
   task automatic send_data(input logic [7:0] d, input logic flip);
      uart_rx = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         tick(16);
      end
`ifdef UART_RX_PARITY_EN
      uart_rx = (^d) ^ flip;
      tick(16);
`endif
   endtask

   // Full frame followed by a short idle-high gap.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
      send_data(d, flip);
      uart_rx = stop;
      tick(16);
      uart_rx = 1'b1;
      tick(4);
   endtask

   task automatic pop_one();
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick(3);
      n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rx_count); end
      n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
      n_tests++; if ({rx_overflow, rx_frame_err, rx_parity_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {rx_overflow, rx_frame_err, rx_parity_err}); end
      resetn = 1'b1;
      tick(5);
   endtask

   task automatic test_basic();
      send_data(8'hA5, 1'b0);
      uart_rx = 1'b1;
      tick(10);
      n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b want 0", rx_valid); end
      tick(1);
      n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_rise: got %b want 1", rx_valid); end
      n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", rx_data); end
      n_tests++; if (rx_count !== 4'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", rx_count); end
      tick(8);
      pop_one();
      n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_valid: got %b want 0", rx_valid); end
      n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL basic_pop_count: got %0d want 0", rx_count); end
      rx_ready = 1'b1;
      tick(3);
      rx_ready = 1'b0;
      n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL basic_ready_empty: got %0d want 0", rx_count); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
      n_tests++; if (rx_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", rx_count); end
      n_tests++; if (rx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", rx_overflow); end
      for (int i = 0; i < 8; i++) begin
         n_tests++; if (rx_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_read%0d: got %h want %h", i, rx_data, 8'(i)); end
         pop_one();
      end
      n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", rx_valid); end
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      n_tests++; if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", rx_overflow); end
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0, 1'b0);
      n_tests++; if (rx_frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_flag: got %b want 1", rx_frame_err); end
      n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL frame_count: got %0d want 0", rx_count); end
      send_frame(8'h5A, 1'b1, 1'b0);
      n_tests++; if (rx_count !== 4'd1) begin n_fail++; $display("FAIL frame_next_count: got %0d want 1", rx_count); end
      n_tests++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL frame_next_data: got %h want 5a", rx_data); end
      pop_one();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      n_tests++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_clr: got %b want 0", rx_frame_err); end
   endtask

   task automatic test_glitch();
      uart_rx = 1'b0;
      tick(4);
      uart_rx = 1'b1;
      tick(30);
      n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", rx_count); end
      n_tests++; if ({rx_overflow, rx_frame_err, rx_parity_err} !== 3'b000) begin n_fail++; $display("FAIL glitch_flags: got %b want 000", {rx_overflow, rx_frame_err, rx_parity_err}); end
      send_frame(8'h96, 1'b1, 1'b0);
      n_tests++; if (rx_data !== 8'h96 || rx_count !== 4'd1) begin n_fail++; $display("FAIL glitch_next: got data %h count %0d want 96 1", rx_data, rx_count); end
      pop_one();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [8];
      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
      n_tests++; if (rx_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", rx_count); end
      send_data(8'h20, 1'b0);
      uart_rx = 1'b1;
      tick(10);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      n_tests++; if (rx_count !== 4'd8) begin n_fail++; $display("FAIL simul_count: got %0d want 8", rx_count); end
      n_tests++; if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL simul_ovf: got %b want 0", rx_overflow); end
      tick(9);
      for (int i = 0; i < 7; i++) exp[i] = 8'h11 + 8'(i);
      exp[7] = 8'h20;
      for (int i = 0; i < 8; i++) begin
         n_tests++; if (rx_data !== exp[i]) begin n_fail++; $display("FAIL simul_read%0d: got %h want %h", i, rx_data, exp[i]); end
         pop_one();
      end
      n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL simul_drained: got %0d want 0", rx_count); end
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h33, 1'b1, 1'b0);
      send_frame(8'h44, 1'b0, 1'b0);
      n_tests++; if (rx_count !== 4'd1 || rx_frame_err !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got count %0d ferr %b want 1 1", rx_count, rx_frame_err); end
      uart_rx = 1'b0;
      tick(16);
      uart_rx = 1'b1;
      tick(56);
      resetn = 1'b0;
      tick(1);
      n_tests++; if (rx_valid !== 1'b0 || rx_count !== 4'd0) begin n_fail++; $display("FAIL mid_reset_fifo: got valid %b count %0d want 0 0", rx_valid, rx_count); end
      n_tests++; if (rx_data !== 8'h00 || rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out: got data %h ferr %b want 00 0", rx_data, rx_frame_err); end
      tick(2);
      resetn = 1'b1;
      tick(200);
      n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL mid_no_push: got %0d want 0", rx_count); end
`ifdef UART_RX_PARITY_EN
      send_frame(8'h81, 1'b1, 1'b1);
      n_tests++; if (rx_parity_err !== 1'b1) begin n_fail++; $display("FAIL par_flag: got %b want 1", rx_parity_err); end
      n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL par_no_push: got %0d want 0", rx_count); end
`else
      send_frame(8'h81, 1'b1, 1'b0);
      n_tests++; if (rx_count !== 4'd1) begin n_fail++; $display("FAIL mid_next_count: got %0d want 1", rx_count); end
      n_tests++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL mid_next_data: got %h want 81", rx_data); end
      n_tests++; if (rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL par_tied: got %b want 0", rx_parity_err); end
`endif
   endtask

   initial begin
      uart_rx  = 1'b1;
      rx_ready = 1'b0;
      err_clr  = 1'b0;
      resetn   = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
